ib_decode_feed: RTL and testbench

IB_DECODE_FEED -- requirements
Module: ib_decode_feed

---
 rtl/ib_decode_feed.sv | 167 ++++++++++++++++
 tb/tb_ib_decode_feed.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ib_decode_feed.sv
// -----------------------------------------------------------------------------
// ib_decode_feed
//
// Purpose: small instruction buffer between the fetch stage and the decode
// stage. It holds up to IB_DEPTH {pc, inst, excp} entries in strict FIFO
// order. Head entry fields are presented to decode and are forced to zero
// while the buffer has nothing valid. A flush discards every entry.
//
// Optional feature (macro IB_BYPASS_EN): when the buffer is empty and decode
// can accept, an offered instruction is forwarded combinationally to the
// head outputs in the same cycle and is not stored. Without the macro, every
// instruction passes through storage and there is no combinational path from
// the fs_* inputs to the ib_* outputs.
//
// Parameters:
//   IB_DEPTH  - number of entries (power of two, 2..16)
//   IB_CNT_W  - occupancy counter width, log2(IB_DEPTH)+1
//
// Ports:
//   clk               in   clock, rising edge
//   rst_n             in   synchronous active-low reset
//   flush_i           in   discard all entries (dominates push/pop)
//   fs_to_ib_valid_i  in   fetch offers an instruction
//   fs_pc_i/inst_i    in   offered PC / instruction word
//   fs_excp_i         in   offered fetch exception code (0 = none)
//   ib_allowin_o      out  buffer can take an instruction (count < depth)
//   ds_allowin_i      in   decode accepts the head entry
//   ib_to_ds_valid_o  out  head entry valid
//   ib_pc_o/inst_o    out  head PC / instruction word (zero when not valid)
//   ib_excp_o         out  head exception code (zero when not valid)
//   ib_count_o        out  current occupancy
// -----------------------------------------------------------------------------
module ib_decode_feed #(
    parameter int IB_DEPTH = 4,
    parameter int IB_CNT_W = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                fs_to_ib_valid_i,
    input  logic [31:0]         fs_pc_i,
    input  logic [31:0]         fs_inst_i,
    input  logic [5:0]          fs_excp_i,
    output logic                ib_allowin_o,
    input  logic                ds_allowin_i,
    output logic                ib_to_ds_valid_o,
    output logic [31:0]         ib_pc_o,
    output logic [31:0]         ib_inst_o,
    output logic [5:0]          ib_excp_o,
    output logic [IB_CNT_W-1:0] ib_count_o
);

    localparam int                   PTR_W    = IB_CNT_W - 1;
    localparam logic [PTR_W-1:0]     PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
    localparam logic [IB_CNT_W-1:0]  CNT_ZERO = {IB_CNT_W{1'b0}};
    localparam logic [IB_CNT_W-1:0]  CNT_ONE  = IB_CNT_W'(1);
    localparam logic [IB_CNT_W-1:0]  CNT_FULL = IB_CNT_W'(IB_DEPTH);

    // Entry storage: deliberately not reset, validity is tracked by count_q.
    logic [31:0] pc_mem_q   [IB_DEPTH];
    logic [31:0] inst_mem_q [IB_DEPTH];
    logic [5:0]  excp_mem_q [IB_DEPTH];

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [IB_CNT_W-1:0] count_q,  count_d;

    logic push_s;
    logic pop_s;
    logic bypass_s;

    // Handshake qualification; full refuses a push even when a pop happens.
    always_comb begin
        ib_allowin_o = (count_q < CNT_FULL);
`ifdef IB_BYPASS_EN
        bypass_s = (count_q == CNT_ZERO) && fs_to_ib_valid_i && ds_allowin_i && !flush_i;
`else
        bypass_s = 1'b0;
`endif
        // A bypassed instruction is consumed directly by decode, never stored.
        push_s = fs_to_ib_valid_i && ib_allowin_o && !flush_i && !bypass_s;
        // Pop only real stored entries; a bypass cycle has count_q == 0.
        pop_s  = (count_q != CNT_ZERO) && ds_allowin_i && !flush_i;
    end

    // Next-state computation for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = PTR_ZERO;
            rd_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            // Depth is a power of two, so natural pointer overflow is the modulo.
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset dominates flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry write port.
    always_ff @(posedge clk) begin
        if (push_s && rst_n) begin
            pc_mem_q[wr_ptr_q]   <= fs_pc_i;
            inst_mem_q[wr_ptr_q] <= fs_inst_i;
            excp_mem_q[wr_ptr_q] <= fs_excp_i;
        end
    end

    // Head presentation toward decode, zeroed whenever nothing is valid.
    always_comb begin
        ib_to_ds_valid_o = 1'b0;
        ib_pc_o          = 32'h0000_0000;
        ib_inst_o        = 32'h0000_0000;
        ib_excp_o        = 6'h00;
`ifdef IB_BYPASS_EN
        if (bypass_s) begin
            ib_to_ds_valid_o = 1'b1;
            ib_pc_o          = fs_pc_i;
            ib_inst_o        = fs_inst_i;
            ib_excp_o        = fs_excp_i;
        end else
`endif
        if (count_q != CNT_ZERO) begin
            ib_to_ds_valid_o = 1'b1;
            ib_pc_o          = pc_mem_q[rd_ptr_q];
            ib_inst_o        = inst_mem_q[rd_ptr_q];
            ib_excp_o        = excp_mem_q[rd_ptr_q];
        end else begin
            ib_to_ds_valid_o = 1'b0;
            ib_pc_o          = 32'h0000_0000;
            ib_inst_o        = 32'h0000_0000;
            ib_excp_o        = 6'h00;
        end
    end

    assign ib_count_o = count_q;

endmodule

// File: tb/tb_ib_decode_feed.sv
// -----------------------------------------------------------------------------
// tb_ib_decode_feed
//
// Self-checking bench for ib_decode_feed in its default build (no bypass).
// A table of per-cycle stimulus rows carries hand-derived expectations for
// valid/allowin/count; a queue scoreboard holds every entry the bench expects
// the buffer to hold and checks the head fields each cycle (zero when empty).
// A randomized drain phase covers pointer wrap-around.
// -----------------------------------------------------------------------------
module tb_ib_decode_feed;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic        fs_to_ib_valid_i;
    logic [31:0] fs_pc_i;
    logic [31:0] fs_inst_i;
    logic [5:0]  fs_excp_i;
    logic        ib_allowin_o;
    logic        ds_allowin_i;
    logic        ib_to_ds_valid_o;
    logic [31:0] ib_pc_o;
    logic [31:0] ib_inst_o;
    logic [5:0]  ib_excp_o;
    logic [2:0]  ib_count_o;

    always #5 clk = ~clk;

    ib_decode_feed #(.IB_DEPTH(4), .IB_CNT_W(3)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush_i          (flush_i),
        .fs_to_ib_valid_i (fs_to_ib_valid_i),
        .fs_pc_i          (fs_pc_i),
        .fs_inst_i        (fs_inst_i),
        .fs_excp_i        (fs_excp_i),
        .ib_allowin_o     (ib_allowin_o),
        .ds_allowin_i     (ds_allowin_i),
        .ib_to_ds_valid_o (ib_to_ds_valid_o),
        .ib_pc_o          (ib_pc_o),
        .ib_inst_o        (ib_inst_o),
        .ib_excp_o        (ib_excp_o),
        .ib_count_o       (ib_count_o)
    );

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic        fsv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  excp;
        logic        dsa;
        logic        ev;   // expected valid during this cycle
        logic        ea;   // expected allowin during this cycle
        logic [2:0]  ec;   // expected count during this cycle
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [5:0]  excp;
    } ent_t;

    localparam int NV = 18;
    vec_t tbl [NV];
    ent_t sb [$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic r, input logic fl, input logic fsv,
                                input logic [31:0] pc, input logic [31:0] inst,
                                input logic [5:0] excp, input logic dsa,
                                input logic ev, input logic ea, input logic [2:0] ec);
        vec_t v;
        v.rst_n = r;  v.flush = fl; v.fsv = fsv; v.pc = pc; v.inst = inst;
        v.excp = excp; v.dsa = dsa; v.ev = ev; v.ea = ea; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, check outputs mid-cycle, then advance the
    // scoreboard exactly as the buffer should on the coming edge.
    task automatic run_cycle(input vec_t v, input bit use_tbl, input string tag);
        ent_t h;
        bit   exp_v;
        bit   do_push;
        bit   do_pop;
        rst_n            = v.rst_n;
        flush_i          = v.flush;
        fs_to_ib_valid_i = v.fsv;
        fs_pc_i          = v.pc;
        fs_inst_i        = v.inst;
        fs_excp_i        = v.excp;
        ds_allowin_i     = v.dsa;
        @(negedge clk);
        exp_v = (sb.size() != 0);
        if (use_tbl) begin
            chk({tag, " valid"},   96'(ib_to_ds_valid_o), 96'(v.ev));
            chk({tag, " allowin"}, 96'(ib_allowin_o),     96'(v.ea));
            chk({tag, " count"},   96'(ib_count_o),       96'(v.ec));
        end else begin
            chk({tag, " valid"},   96'(ib_to_ds_valid_o), 96'(exp_v));
            chk({tag, " allowin"}, 96'(ib_allowin_o),     96'(sb.size() < 4));
            chk({tag, " count"},   96'(ib_count_o),       96'(sb.size()));
        end
        if (exp_v) begin
            h = sb[0];
        end else begin
            h = '{32'h0, 32'h0, 6'h0};
        end
        chk({tag, " head"}, 96'({ib_pc_o, ib_inst_o, ib_excp_o}), 96'({h.pc, h.inst, h.excp}));
        if (!v.rst_n || v.flush) begin
            sb.delete();
        end else begin
            do_push = v.fsv && (sb.size() < 4);
            do_pop  = exp_v && v.dsa;
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back('{v.pc, v.inst, v.excp});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        int   pushed;
        int   c;
        bit   acc;

        // Hand-derived rows: expectations are the state seen during the row.
        tbl[0]  = mk(1, 0, 0, 32'h0,         32'h0,         6'h00, 0, 0, 1, 3'd0); // post-reset
        tbl[1]  = mk(1, 0, 1, 32'h1c000000,  32'h02804c0c,  6'h00, 1, 0, 1, 3'd0); // push, no same-cycle valid
        tbl[2]  = mk(1, 0, 0, 32'h0,         32'h0,         6'h00, 1, 1, 1, 3'd1); // visible, popped
        tbl[3]  = mk(1, 0, 0, 32'h0,         32'h0,         6'h00, 0, 0, 1, 3'd0); // empty again
        tbl[4]  = mk(1, 0, 1, 32'h1c000100,  32'h11111111,  6'h00, 0, 0, 1, 3'd0); // A
        tbl[5]  = mk(1, 0, 1, 32'h1c000104,  32'h22222222,  6'h08, 0, 1, 1, 3'd1); // B
        tbl[6]  = mk(1, 0, 1, 32'h1c000108,  32'h33333333,  6'h00, 0, 1, 1, 3'd2); // C
        tbl[7]  = mk(1, 0, 1, 32'h1c00010c,  32'h44444444,  6'h3f, 0, 1, 1, 3'd3); // D
        tbl[8]  = mk(1, 0, 1, 32'h1c000110,  32'h55555555,  6'h01, 0, 1, 0, 3'd4); // E refused
        tbl[9]  = mk(1, 0, 1, 32'h1c000110,  32'h55555555,  6'h01, 1, 1, 0, 3'd4); // full: pop only
        tbl[10] = mk(1, 0, 0, 32'h0,         32'h0,         6'h00, 0, 1, 1, 3'd3); // allowin back
        tbl[11] = mk(1, 1, 1, 32'h1c000200,  32'h66666666,  6'h00, 1, 1, 1, 3'd3); // flush + push + pop
        tbl[12] = mk(1, 0, 0, 32'h0,         32'h0,         6'h00, 1, 0, 1, 3'd0);
        tbl[13] = mk(1, 0, 0, 32'h0,         32'h0,         6'h00, 1, 0, 1, 3'd0);
        tbl[14] = mk(1, 0, 1, 32'h1c000300,  32'h77777777,  6'h00, 0, 0, 1, 3'd0); // G
        tbl[15] = mk(1, 0, 1, 32'h1c000304,  32'h88888888,  6'h02, 0, 1, 1, 3'd1); // H
        tbl[16] = mk(0, 0, 1, 32'h1c000308,  32'h99999999,  6'h00, 1, 1, 1, 3'd2); // reset mid-run
        tbl[17] = mk(1, 0, 0, 32'h0,         32'h0,         6'h00, 1, 0, 1, 3'd0);

        rst_n = 1'b0; flush_i = 1'b0; fs_to_ib_valid_i = 1'b0;
        fs_pc_i = 32'h0; fs_inst_i = 32'h0; fs_excp_i = 6'h0; ds_allowin_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            run_cycle(tbl[i], 1'b1, $sformatf("row%0d", i));
        end

        // Ten sequential PCs under random decode back-pressure; wraps pointers.
        pushed = 0;
        c      = 0;
        while ((pushed < 10 || sb.size() != 0) && c < 400) begin
            v   = mk(1, 0, (pushed < 10), 32'(pushed * 4), 32'hA000_0000 + 32'(pushed),
                     6'(pushed), 1'($urandom_range(0, 1)), 0, 0, 3'd0);
            acc = (pushed < 10) && (sb.size() < 4);
            run_cycle(v, 1'b0, $sformatf("rnd%0d", c));
            if (acc) pushed++;
            c++;
        end
        if (pushed < 10 || sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rnd_timeout: got pushed=%0d left=%0d required pushed=10 left=0",
                     pushed, sb.size());
        end
        ds_allowin_i     = 1'b0;
        fs_to_ib_valid_i = 1'b0;
        @(negedge clk);
        chk("final count", 96'(ib_count_o), 96'(0));
        chk("final valid", 96'(ib_to_ds_valid_o), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
